// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding (common with uart_slave), data width
// and frame lengths.
package uart_pkg;

  localparam int UART_DATA_W           = 8;
  localparam int UART_FRAME_BITS_PAR   = 11;  // start + 8 data + parity + stop
  localparam int UART_FRAME_BITS_NOPAR = 10;  // start + 8 data + stop

  typedef enum logic [2:0] {
    ST_IDLE   = 3'b000,
    ST_START  = 3'b001,
    ST_DATA   = 3'b010,
    ST_PARITY = 3'b011,
    ST_STOP   = 3'b100
  } uart_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the
// terminal count with a one-cycle tick. Held at zero while en is low.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int             CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]  TERM = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || !en)       cnt <= '0;
    else if (cnt == TERM) cnt <= '0;
    else                  cnt <= cnt + 1'b1;
  end

  assign tick = en && (cnt == TERM);

endmodule

// File: rtl/uart_master.sv
// UART transmitter: byte in over valid/ready, LSB-first serial frame out.
// Define UART_MASTER_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_master
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [UART_DATA_W-1:0] tx_data,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  output logic                   u_tx,
  output logic                   tx_busy,
  output logic                   tx_done
);

  uart_state_e            state, state_nxt;
  logic [UART_DATA_W-1:0] sreg, sreg_nxt;
  logic [2:0]             bit_idx, bit_idx_nxt;
  logic                   u_tx_nxt, done_nxt;
  logic                   baud_en, baud_tick;
`ifdef UART_MASTER_PARITY_EN
  logic                   par, par_nxt;
`endif

  assign baud_en  = (state != ST_IDLE);
  assign tx_ready = (state == ST_IDLE);
  assign tx_busy  = baud_en;

  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk  (clk),
    .rst  (rst),
    .en   (baud_en),
    .tick (baud_tick)
  );

  always_comb begin
    state_nxt   = state;
    sreg_nxt    = sreg;
    bit_idx_nxt = bit_idx;
    done_nxt    = 1'b0;
`ifdef UART_MASTER_PARITY_EN
    par_nxt     = par;
`endif
    case (state)
      ST_IDLE: if (tx_valid) begin
        state_nxt   = ST_START;
        sreg_nxt    = tx_data;
        bit_idx_nxt = 3'd0;
`ifdef UART_MASTER_PARITY_EN
        par_nxt     = ^tx_data;
`endif
      end
      ST_START: if (baud_tick) state_nxt = ST_DATA;
      ST_DATA: if (baud_tick) begin
        sreg_nxt    = sreg >> 1;
        bit_idx_nxt = bit_idx + 3'd1;
        if (bit_idx == 3'd7) begin
`ifdef UART_MASTER_PARITY_EN
          state_nxt = ST_PARITY;
`else
          state_nxt = ST_STOP;
`endif
        end
      end
`ifdef UART_MASTER_PARITY_EN
      ST_PARITY: if (baud_tick) state_nxt = ST_STOP;
`endif
      ST_STOP: if (baud_tick) begin
        state_nxt = ST_IDLE;
        done_nxt  = 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Line value is registered from the next state so the start bit appears in
  // the cycle right after the handshake edge.
  always_comb begin
    u_tx_nxt = 1'b1;
    case (state_nxt)
      ST_START:  u_tx_nxt = 1'b0;
      ST_DATA:   u_tx_nxt = sreg_nxt[0];
`ifdef UART_MASTER_PARITY_EN
      ST_PARITY: u_tx_nxt = par_nxt;
`endif
      default:   u_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      sreg    <= '0;
      bit_idx <= 3'd0;
      u_tx    <= 1'b1;
      tx_done <= 1'b0;
`ifdef UART_MASTER_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      sreg    <= sreg_nxt;
      bit_idx <= bit_idx_nxt;
      u_tx    <= u_tx_nxt;
      tx_done <= done_nxt;
`ifdef UART_MASTER_PARITY_EN
      par     <= par_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_uart_master.sv
// Bench for uart_master: two instances (1 and 4 clocks per bit) checked cycle
// by cycle against a frame model built from the byte and the bit period.
module tb_uart_master;

  localparam int CPB0 = 1;
  localparam int CPB1 = 4;
`ifdef UART_MASTER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int NBITS = PAR ? 11 : 10;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [1:0][7:0] tx_data;
  logic [1:0]      tx_valid, tx_ready, u_tx, tx_busy, tx_done;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_master #(.CLKS_PER_BIT(CPB0)) dut0 (
    .clk(clk), .rst(rst), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready[0]), .u_tx(u_tx[0]), .tx_busy(tx_busy[0]), .tx_done(tx_done[0])
  );

  uart_master #(.CLKS_PER_BIT(CPB1)) dut1 (
    .clk(clk), .rst(rst), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready[1]), .u_tx(u_tx[1]), .tx_busy(tx_busy[1]), .tx_done(tx_done[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int cpb(input int d);
    return (d == 0) ? CPB0 : CPB1;
  endfunction

  // Frame position 0 is start, 1..8 data LSB first, then parity (odd count of
  // ones gives 1) if enabled, then stop.
  function automatic logic exp_bit(input logic [7:0] b, input int pos);
    if (pos == 0) return 1'b0;
    if (pos <= 8) return b[pos-1];
    if (PAR && pos == 9) return ($countones(b) % 2) == 1;
    return 1'b1;
  endfunction

  task automatic idle_check(input int d, input int n);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("d%0d idle u_tx", d),  u_tx[d],     1);
      chk($sformatf("d%0d idle ready", d), tx_ready[d], 1);
      chk($sformatf("d%0d idle busy", d),  tx_busy[d],  0);
      chk($sformatf("d%0d idle done", d),  tx_done[d],  0);
      @(posedge clk); #1;
    end
  endtask

  // Entry: idle cycle with tx_valid/tx_data already driven with b.
  // Exit: inside the tx_done cycle. With chain set, nb is offered mid-frame
  // and left pending so it is taken on the done cycle.
  task automatic run_frame(input int d, input logic [7:0] b, input bit chain,
                           input logic [7:0] nb);
    int f, mid;
    f   = NBITS * cpb(d);
    mid = $urandom_range(1, f - 1);
    @(posedge clk); #1;
    tx_valid[d] = 1'b0;
    tx_data[d]  = 8'($urandom);
    for (int k = 0; k < f; k++) begin
      chk($sformatf("d%0d byte %02h cyc%0d u_tx", d, b, k), u_tx[d], exp_bit(b, k / cpb(d)));
      chk($sformatf("d%0d cyc%0d busy", d, k),  tx_busy[d],  1);
      chk($sformatf("d%0d cyc%0d ready", d, k), tx_ready[d], 0);
      chk($sformatf("d%0d cyc%0d done", d, k),  tx_done[d],  0);
      if (chain && k == mid) begin
        tx_valid[d] = 1'b1;
        tx_data[d]  = nb;
      end
      @(posedge clk); #1;
    end
    chk($sformatf("d%0d end done", d),  tx_done[d],  1);
    chk($sformatf("d%0d end ready", d), tx_ready[d], 1);
    chk($sformatf("d%0d end busy", d),  tx_busy[d],  0);
    chk($sformatf("d%0d end u_tx", d),  u_tx[d],     1);
  endtask

  task automatic send(input int d, input logic [7:0] b);
    tx_valid[d] = 1'b1;
    tx_data[d]  = b;
    run_frame(d, b, 1'b0, 8'h00);
    @(posedge clk); #1;
    idle_check(d, 1);
  endtask

  initial begin
    logic [7:0] b, nb;
    bit         chain;
    tx_valid = '0;
    tx_data  = '0;
    rst      = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d rst u_tx", d),  u_tx[d],     1);
      chk($sformatf("d%0d rst ready", d), tx_ready[d], 1);
      chk($sformatf("d%0d rst busy", d),  tx_busy[d],  0);
      chk($sformatf("d%0d rst done", d),  tx_done[d],  0);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    idle_check(0, 20);

    send(0, 8'hA5);
    send(1, 8'h07);

    // Back-to-back: exactly one idle cycle (the done cycle) between frames.
    tx_valid[0] = 1'b1;
    tx_data[0]  = 8'h00;
    run_frame(0, 8'h00, 1'b1, 8'hFF);
    run_frame(0, 8'hFF, 1'b0, 8'h00);
    @(posedge clk); #1;
    idle_check(0, 2);

    // Reset in the second cycle of data bit 3 on the 4-clock instance, while
    // the other instance sees rst and tx_valid together.
    b = 8'($urandom);
    tx_valid[1] = 1'b1;
    tx_data[1]  = b;
    @(posedge clk); #1;
    tx_valid[1] = 1'b0;
    repeat (17) @(posedge clk);
    #1;
    chk("d1 pre-rst bit3", u_tx[1], b[3]);
    rst = 1'b1;
    tx_valid[0] = 1'b1;
    tx_data[0]  = 8'h81;
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d midrst u_tx", d),  u_tx[d],     1);
      chk($sformatf("d%0d midrst ready", d), tx_ready[d], 1);
      chk($sformatf("d%0d midrst busy", d),  tx_busy[d],  0);
      chk($sformatf("d%0d midrst done", d),  tx_done[d],  0);
    end
    rst = 1'b0;
    tx_valid[0] = 1'b0;
    @(posedge clk); #1;
    idle_check(1, 2 * NBITS * CPB1);
    idle_check(0, 2);
    send(1, 8'h3C);

    // Randomised streams with random chaining and idle gaps.
    for (int d = 0; d < 2; d++) begin
      b = 8'($urandom);
      tx_valid[d] = 1'b1;
      tx_data[d]  = b;
      for (int i = 0; i < 12; i++) begin
        nb    = 8'($urandom);
        chain = (i < 11) && ($urandom_range(0, 1) == 1);
        run_frame(d, b, chain, nb);
        if (!chain) begin
          @(posedge clk); #1;
          idle_check(d, $urandom_range(1, 3));
          if (i < 11) begin
            tx_valid[d] = 1'b1;
            tx_data[d]  = nb;
          end
        end
        b = nb;
      end
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
